// File: rtl/alu_cmd_sequencer_if.sv
// Bus bundle between the command producer, the ALU and the result consumer.
// master = sequencer view, slave = environment view (producer, ALU, consumer).
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int WFUN  = 4,
  parameter int WFLAG = 4
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [WIDTH-1:0] CMD_A;
  logic [WIDTH-1:0] CMD_B;
  logic [WFUN-1:0]  CMD_FUN;

  logic [WIDTH-1:0] ALU_A;
  logic [WIDTH-1:0] ALU_B;
  logic [WFUN-1:0]  ALU_FUN;
  logic [WIDTH-1:0] ALU_RES;
  logic [WFLAG-1:0] ALU_FLAGS;

  logic             RES_VALID;
  logic             RES_READY;
  logic [WIDTH-1:0] RES_DATA;
  logic [WFLAG-1:0] RES_FLAGS;
  logic [WFUN-1:0]  RES_FUN;

  modport master (
    input  CMD_VALID, CMD_A, CMD_B, CMD_FUN, ALU_RES, ALU_FLAGS, RES_READY,
    output CMD_READY, ALU_A, ALU_B, ALU_FUN, RES_VALID, RES_DATA, RES_FLAGS, RES_FUN
  );

  modport slave (
    output CMD_VALID, CMD_A, CMD_B, CMD_FUN, ALU_RES, ALU_FLAGS, RES_READY,
    input  CMD_READY, ALU_A, ALU_B, ALU_FUN, RES_VALID, RES_DATA, RES_FLAGS, RES_FUN
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO in front of ALU_16bit: issues one command at a time, waits out the
// ALU latency, and holds the captured result on a valid/ready port.
//
//  state | meaning
//  IDLE  | nothing in flight; pop as soon as the FIFO has an entry
//  WAIT  | ALU inputs driven, counting down the ALU latency
//  HOLD  | result captured and presented until the consumer takes it
module alu_cmd_sequencer #(
  parameter int WIDTH      = 16,
  parameter int WFUN       = 4,
  parameter int WFLAG      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  alu_cmd_sequencer_if.master         bus,
  output logic                        BUSY,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_CNT
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int LW   = $clog2(ALU_LAT + 1);
  localparam int EW   = 2 * WIDTH + WFUN;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t state_q, state_d;
  logic [LW-1:0]   wait_q, wait_d;
  logic            res_valid_q, res_valid_d;
  logic            pop, push, capture;
  logic            fifo_empty, fifo_full;

  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] cnt_q;
  logic [EW-1:0]   head;

  logic [WIDTH-1:0] alu_a_q, alu_b_q, res_data_q;
  logic [WFUN-1:0]  alu_fun_q, res_fun_q;
  logic [WFLAG-1:0] res_flags_q;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNTW'(FIFO_DEPTH));
  // Ready depends only on the registered count, so a same-cycle pop never frees a full FIFO.
  assign push       = bus.CMD_VALID & ~fifo_full;
  assign head       = mem[rd_ptr];

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    res_valid_d = res_valid_q;
    pop         = 1'b0;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          wait_d  = LW'(ALU_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 1'b1;
        end else begin
          capture     = 1'b1;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (bus.RES_READY) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            wait_d  = LW'(ALU_LAT);
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {bus.CMD_A, bus.CMD_B, bus.CMD_FUN};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      res_valid_q <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_fun_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      res_valid_q <= res_valid_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr                          <= rd_ptr + 1'b1;
        {alu_a_q, alu_b_q, alu_fun_q}   <= head;
      end
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      if (capture) begin
        res_data_q  <= bus.ALU_RES;
        res_flags_q <= bus.ALU_FLAGS;
        res_fun_q   <= alu_fun_q;
      end
    end
  end

  assign bus.CMD_READY = ~fifo_full;
  assign bus.ALU_A     = alu_a_q;
  assign bus.ALU_B     = alu_b_q;
  assign bus.ALU_FUN   = alu_fun_q;
  assign bus.RES_VALID = res_valid_q;
  assign bus.RES_DATA  = res_data_q;
  assign bus.RES_FLAGS = res_flags_q;
  assign bus.RES_FUN   = res_fun_q;
  assign BUSY          = (state_q != IDLE) | ~fifo_empty;
  assign FIFO_CNT      = cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed and randomized checks of alu_cmd_sequencer against a registered ALU stub.
module tb_alu_cmd_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BUSY;
  logic [2:0] FIFO_CNT;
  int         n_chk  = 0;
  int         n_pass = 0;

  alu_cmd_sequencer_if #(.WIDTH(16), .WFUN(4), .WFLAG(4)) bus_i ();

  alu_cmd_sequencer #(
    .WIDTH(16), .WFUN(4), .WFLAG(4), .FIFO_DEPTH(4), .ALU_LAT(1)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus_i), .BUSY(BUSY), .FIFO_CNT(FIFO_CNT)
  );

  always #5 CLK = ~CLK;

  // flags = {carry, parity, negative, zero}
  function automatic logic [19:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] f);
    logic [16:0] r;
    r = '0;
    case (f)
      4'b0000: r = {1'b0, a & b};
      4'b0001: r = {1'b0, a | b};
      4'b0010: r = {1'b0, a ^ b};
      4'b0011: r = {1'b0, ~(a & b)};
      4'b0100: r = {1'b0, ~a};
      4'b0101: r = {1'b0, a} + {1'b0, b};
      4'b0110: r = {1'b0, a} - {1'b0, b};
      4'b0111: r = {1'b0, a * b};
      4'b1000: r = {1'b0, a << 1};
      4'b1001: r = {1'b0, a >> 1};
      4'b1010: r = {16'd0, a == b};
      4'b1011: r = (b == 16'd0) ? 17'd0 : {1'b0, a / b};
      4'b1100: r = {16'd0, a > b};
      default: r = '0;
    endcase
    return {r[16], ^r[15:0], r[15], r[15:0] == 16'd0, r[15:0]};
  endfunction

  always @(posedge CLK)
    {bus_i.ALU_FLAGS, bus_i.ALU_RES} <= alu_model(bus_i.ALU_A, bus_i.ALU_B, bus_i.ALU_FUN);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
  endtask

  task automatic send_single(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                             input logic [15:0] exp_res, input logic [3:0] exp_flags);
    bus_i.CMD_VALID = 1'b1;
    bus_i.CMD_A = a; bus_i.CMD_B = b; bus_i.CMD_FUN = f;
    @(negedge CLK);
    bus_i.CMD_VALID = 1'b0;
    check("single_cnt_k", FIFO_CNT, 1);
    @(negedge CLK);
    check("single_alu_a", bus_i.ALU_A, a);
    check("single_alu_fun", bus_i.ALU_FUN, f);
    check("single_valid_k1", bus_i.RES_VALID, 0);
    @(negedge CLK);
    check("single_valid_k2", bus_i.RES_VALID, 0);
    @(negedge CLK);
    check("single_valid_k3", bus_i.RES_VALID, 1);
    check("single_data", bus_i.RES_DATA, exp_res);
    check("single_flags", bus_i.RES_FLAGS, exp_flags);
    check("single_fun", bus_i.RES_FUN, f);
    @(negedge CLK);
    check("single_valid_drop", bus_i.RES_VALID, 0);
    check("single_busy_end", BUSY, 0);
  endtask

  logic [15:0] fa  [5] = '{16'd100, 16'd7, 16'h8000, 16'hffff, 16'd3};
  logic [15:0] fb  [5] = '{16'd23,  16'd9, 16'h8000, 16'h0001, 16'd3};
  logic [3:0]  ff  [5] = '{4'b0101, 4'b0110, 4'b0101, 4'b0101, 4'b0111};
  logic [15:0] fex [5] = '{16'd123, 16'hfffe, 16'h0000, 16'h0000, 16'd9};

  initial begin
    int got, last;
    int acc, rcv;
    logic [23:0] exp_q[$];
    logic [23:0] e;

    RST = 1'b0;
    bus_i.CMD_VALID = 1'b0; bus_i.CMD_A = '0; bus_i.CMD_B = '0; bus_i.CMD_FUN = '0;
    bus_i.RES_READY = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_cmd_ready", bus_i.CMD_READY, 1);
    check("rst_res_valid", bus_i.RES_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_fifo_cnt", FIFO_CNT, 0);
    check("rst_res_data", bus_i.RES_DATA, 0);
    check("rst_res_flags", bus_i.RES_FLAGS, 0);
    check("rst_res_fun", bus_i.RES_FUN, 0);
    check("rst_alu_a", bus_i.ALU_A, 0);

    bus_i.RES_READY = 1'b1;
    send_single(16'd10, 16'd5, 4'b0101, 16'd15, 4'h0);
    send_single(16'd10, 16'd5, 4'b1011, 16'd2, 4'h4);
    repeat (2) @(negedge CLK);
    check("idle_hold_alu_a", bus_i.ALU_A, 10);
    check("idle_hold_alu_fun", bus_i.ALU_FUN, 4'b1011);

    // fill the FIFO while the consumer stalls
    bus_i.RES_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_i.CMD_VALID = 1'b1;
      bus_i.CMD_A = fa[i]; bus_i.CMD_B = fb[i]; bus_i.CMD_FUN = ff[i];
      @(negedge CLK);
    end
    check("fill_cnt", FIFO_CNT, 4);
    check("fill_ready_low", bus_i.CMD_READY, 0);
    check("fill_res_valid", bus_i.RES_VALID, 1);
    check("fill_first_data", bus_i.RES_DATA, fex[0]);
    bus_i.CMD_A = 16'hdead; bus_i.CMD_B = 16'hbeef; bus_i.CMD_FUN = 4'h1;
    repeat (3) @(negedge CLK);
    check("full_held_cnt", FIFO_CNT, 4);
    check("full_stable_valid", bus_i.RES_VALID, 1);
    check("full_stable_data", bus_i.RES_DATA, fex[0]);
    check("full_stable_fun", bus_i.RES_FUN, ff[0]);
    bus_i.CMD_VALID = 1'b0;

    bus_i.RES_READY = 1'b1;
    @(negedge CLK);
    check("drain_ready_rise", bus_i.CMD_READY, 1);
    check("drain_cnt", FIFO_CNT, 3);
    check("drain_valid_drop", bus_i.RES_VALID, 0);
    got = 1; last = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge CLK);
      if (bus_i.RES_VALID) begin
        if (got < 5) begin
          check("drain_data", bus_i.RES_DATA, fex[got]);
          check("drain_fun", bus_i.RES_FUN, ff[got]);
        end
        if (got > 1) check("drain_spacing", cyc - last, 3);
        last = cyc;
        got++;
      end
    end
    check("drain_count", got, 5);
    check("drain_busy", BUSY, 0);
    check("drain_cnt_end", FIFO_CNT, 0);

    // reset while a command is in WAIT with another queued
    bus_i.CMD_VALID = 1'b1;
    bus_i.CMD_A = 16'd1; bus_i.CMD_B = 16'd2; bus_i.CMD_FUN = 4'b0101;
    repeat (2) @(negedge CLK);
    bus_i.CMD_VALID = 1'b0;
    check("pre_rst_cnt", FIFO_CNT, 1);
    RST = 1'b0;
    #1;
    check("midrst_cnt", FIFO_CNT, 0);
    check("midrst_valid", bus_i.RES_VALID, 0);
    check("midrst_ready", bus_i.CMD_READY, 1);
    check("midrst_busy", BUSY, 0);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("post_rst_quiet", bus_i.RES_VALID, 0);
    end

    // randomized traffic against the ALU model
    acc = 0; rcv = 0;
    for (int cyc = 0; cyc < 20000 && rcv < 200; cyc++) begin
      @(negedge CLK);
      bus_i.CMD_VALID = (acc < 200) && ($urandom_range(0, 3) != 0);
      bus_i.CMD_A     = 16'($urandom_range(0, 65535));
      bus_i.CMD_B     = 16'($urandom_range(0, 65535));
      bus_i.CMD_FUN   = 4'($urandom_range(0, 15));
      bus_i.RES_READY = ($urandom_range(0, 2) != 0);
      #1;
      if (bus_i.CMD_VALID && bus_i.CMD_READY) begin
        exp_q.push_back({alu_model(bus_i.CMD_A, bus_i.CMD_B, bus_i.CMD_FUN), bus_i.CMD_FUN});
        acc++;
      end
      if (bus_i.RES_VALID && bus_i.RES_READY) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rand_data", bus_i.RES_DATA, e[19:4]);
          check("rand_flags", bus_i.RES_FLAGS, e[23:20]);
          check("rand_fun", bus_i.RES_FUN, e[3:0]);
        end
        rcv++;
      end
    end
    bus_i.CMD_VALID = 1'b0;
    bus_i.RES_READY = 1'b1;
    check("rand_accepted", acc, 200);
    check("rand_received", rcv, 200);
    check("rand_leftover", exp_q.size(), 0);
    repeat (3) @(negedge CLK);
    check("rand_busy_end", BUSY, 0);
    check("rand_no_extra", bus_i.RES_VALID, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
